// File: rtl/mem_io_responder.sv
// Generic circular FIFO used for the console TX and RX queues.
// Latency: a pushed byte is visible at o_dat the cycle after the push edge.
// Backpressure: none internally; the caller gates i_push on not-full and i_pop on not-empty.
// Ports: clk_in/rst_in clock and async active-low reset; i_push/i_dat write side;
//        i_pop advances the head; o_dat is the head entry; o_count is the occupancy.
module mem_io_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     i_push,
    input  logic [W-1:0]             i_dat,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dat,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    // Storage is left unreset; only the pointers define which entries are live.
    always_ff @(posedge clk_in) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dat   = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// Memory-bus responder: unified RAM plus a byte-wide console I/O window (TX/RX FIFOs, halt flag).
// Latency: writes take effect at the commit edge; reads return on cpu_din one cycle after commit.
// Backpressure: rdy_out drops while the TX FIFO is full, stalling the CPU; rx_ready drops while RX is full.
// Ports: clk_in/rst_in clock and async active-low reset; cpu_a/cpu_wr/cpu_dout/cpu_din CPU bus;
//        rdy_out CPU stall; tx_* console-out stream; rx_* console-in stream; halt_o sticky end flag.
module mem_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        rdy_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halt_o
);
    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam logic [TX_PW:0] TX_FULL_CNT = (TX_PW+1)'(TX_DEPTH);
    localparam logic [RX_PW:0] RX_FULL_CNT = (RX_PW+1)'(RX_DEPTH);
    localparam logic [17:0]    IO_DATA_ADDR = 18'h30000;
    localparam logic [17:0]    IO_CTRL_ADDR = 18'h30004;

    logic [7:0]            r_ram [2**RAM_ADDR_W];
    logic [7:0]            r_ram_rd;
    logic [7:0]            r_io_rd;
    logic                  r_din_sel_ram;
    logic                  r_halt;

    logic                  w_commit;
    logic                  w_is_io;
    logic                  w_io_data;
    logic                  w_io_ctrl;
    logic [RAM_ADDR_W-1:0] w_ram_addr;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic                  w_rd_commit;
    logic                  w_tx_push;
    logic                  w_tx_pop;
    logic                  w_tx_full;
    logic [TX_PW:0]        w_tx_count;
    logic                  w_rx_push;
    logic                  w_rx_pop;
    logic                  w_rx_nonempty;
    logic [RX_PW:0]        w_rx_count;
    logic [7:0]            w_rx_head;
    logic [7:0]            w_io_rd;
    logic                  w_unused_addr;

    // Only the low 18 address bits are decoded.
    assign w_unused_addr = ^cpu_a[31:18];

    // rdy_out comes purely from the registered TX occupancy, so the bus
    // never sees a combinational loop through the stall signal.
    assign w_tx_full = (w_tx_count == TX_FULL_CNT);
    assign rdy_out   = !w_tx_full;
    assign w_commit  = rdy_out;

    assign w_is_io    = (cpu_a[17:16] == 2'b11);
    assign w_io_data  = (cpu_a[17:0] == IO_DATA_ADDR);
    assign w_io_ctrl  = (cpu_a[17:0] == IO_CTRL_ADDR);
    // Bits above RAM_ADDR_W are dropped, so 0x2xxxx aliases 0x0xxxx.
    assign w_ram_addr = cpu_a[RAM_ADDR_W-1:0];

    assign w_rd_commit = w_commit && !cpu_wr;
    assign w_ram_we    = w_commit && cpu_wr && !w_is_io;
    assign w_ram_re    = w_rd_commit && !w_is_io;

    assign w_tx_push = w_commit && cpu_wr && w_io_data;
    assign w_tx_pop  = tx_valid && tx_ready;
    assign tx_valid  = (w_tx_count != '0);

    assign rx_ready      = (w_rx_count != RX_FULL_CNT);
    assign w_rx_push     = rx_valid && rx_ready;
    assign w_rx_nonempty = (w_rx_count != '0);
    // Occupancy is sampled before the edge, so a byte arriving into an empty
    // FIFO on the same cycle as a CPU read is not bypassed to the CPU.
    assign w_rx_pop      = w_rd_commit && w_io_data && w_rx_nonempty;

    mem_io_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_tx_push),
        .i_dat   (cpu_dout),
        .i_pop   (w_tx_pop),
        .o_dat   (tx_data),
        .o_count (w_tx_count)
    );

    mem_io_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_rx_push),
        .i_dat   (rx_data),
        .i_pop   (w_rx_pop),
        .o_dat   (w_rx_head),
        .o_count (w_rx_count)
    );

    // I/O read data; undefined window addresses and an empty RX read as zero.
    always_comb begin
        w_io_rd = 8'h00;
        if (w_io_data) begin
            if (w_rx_nonempty) begin
                w_io_rd = w_rx_head;
            end
        end else if (w_io_ctrl) begin
            w_io_rd = {6'b0, w_tx_full, w_rx_nonempty};
        end
    end

    // RAM array and its read register stay unreset so they map onto block RAM;
    // cpu_din is steered away from r_ram_rd during and after reset instead.
    always_ff @(posedge clk_in) begin
        if (w_ram_we) begin
            r_ram[w_ram_addr] <= cpu_dout;
        end
        if (w_ram_re) begin
            r_ram_rd <= r_ram[w_ram_addr];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_din_sel_ram <= 1'b0;
            r_io_rd       <= 8'h00;
            r_halt        <= 1'b0;
        end else begin
            if (w_rd_commit) begin
                r_din_sel_ram <= !w_is_io;
                if (w_is_io) begin
                    r_io_rd <= w_io_rd;
                end
            end
            if (w_commit && cpu_wr && w_io_ctrl) begin
                r_halt <= 1'b1;
            end
        end
    end

    // Both read registers hold between reads, so cpu_din keeps its last value.
    assign cpu_din = r_din_sel_ram ? r_ram_rd : r_io_rd;
    assign halt_o  = r_halt;
endmodule
